vga_frame_monitor: RTL and testbench

Receive-side counterpart of the game's VGA video path. The block samples the `hsync`/`vsync`/`rgb` stream that the display pipeline drives off-chip. From the sync edges alone it recovers pixel coordinates and checks the 640x480@60 timing against the generator's constants. It also produces per-frame statistics: a checksum and a count of key-colour pixels, such as the collision colour 12'hf99. It sits beside the top level as an on-board self-check and as the scoreboard's hardware twin in simulation.

---
 rtl/vga_frame_monitor_pkg.sv | 55 +++++
 rtl/vga_frame_monitor_if.sv | 31 +++
 rtl/vga_frame_monitor_sync_edge_detect.sv | 23 ++
 rtl/vga_frame_monitor.sv | 164 ++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_frame_monitor_pkg.sv
// Shared 640x480@60 timing constants, derived sync positions and the
// monitor's lock-state type. Used by both the video generator and the monitor.
package vga_frame_monitor_pkg;

    localparam int POS_W = 10;
    localparam int RGB_W = 12;
    localparam int SUM_W = 24;
    localparam int KEY_W = 19;
    localparam int ERR_W = 8;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam logic [RGB_W-1:0] DEF_KEY_COLOR = 12'hf99;

    // Sync edges sit right after the front porch and right after the sync pulse.
    function automatic int sync_fall_pos(input int display, input int front);
        return display + front;
    endfunction

    function automatic int sync_rise_pos(input int display, input int front, input int sync);
        return display + front + sync;
    endfunction

    function automatic int last_pos(input int display, input int front, input int sync,
                                    input int back);
        return display + front + sync + back - 1;
    endfunction

    // Derived positions for the standard mode: 656, 752, 799 and 490, 492, 524.
    localparam int DEF_H_FALL = sync_fall_pos(DEF_H_DISPLAY, DEF_H_FRONT);
    localparam int DEF_H_RISE = sync_rise_pos(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC);
    localparam int DEF_H_LAST = last_pos(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_FALL = sync_fall_pos(DEF_V_DISPLAY, DEF_V_FRONT);
    localparam int DEF_V_RISE = sync_rise_pos(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC);
    localparam int DEF_V_LAST = last_pos(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] v,
                                                  input logic [POS_W-1:0] last);
        return (v == last) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_frame_monitor_if.sv
// Video stream in (from the display pipeline) and recovered position,
// lock status and per-frame statistics out.
interface vga_frame_monitor_if;
    import vga_frame_monitor_pkg::*;

    logic              p_tick;
    logic              hsync;
    logic              vsync;
    logic [RGB_W-1:0]  rgb;
    logic [POS_W-1:0]  px_x;
    logic [POS_W-1:0]  px_y;
    logic              active;
    logic              locked;
    logic              frame_done;
    logic              frame_valid;
    logic [SUM_W-1:0]  frame_sum;
    logic [KEY_W-1:0]  key_count;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output p_tick, hsync, vsync, rgb,
        input  px_x, px_y, active, locked, frame_done, frame_valid,
               frame_sum, key_count, err_count
    );

    modport slave (
        input  p_tick, hsync, vsync, rgb,
        output px_x, px_y, active, locked, frame_done, frame_valid,
               frame_sum, key_count, err_count
    );
endinterface

// File: rtl/vga_frame_monitor_sync_edge_detect.sv
// Sync history sampled on pixel ticks; strobes are only valid on a tick.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic p_tick,
    input  logic sync_in,
    output logic fall,
    output logic rise
);
    logic last;

    // remember the sync level carried by the previous pixel tick
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (p_tick) begin
            last <= sync_in;
        end
    end

    assign fall = p_tick & last & ~sync_in;
    assign rise = p_tick & ~last & sync_in;
endmodule

// File: rtl/vga_frame_monitor.sv
// Recovers pixel coordinates from the sync edges, checks them against the
// expected timing, locks onto a clean stream and gathers per-frame stats.
// hcnt/vcnt hold the position of the next sample to arrive; a misplaced
// hsync/vsync fall re-labels the current sample so the stream realigns.
module vga_frame_monitor
    import vga_frame_monitor_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter logic [RGB_W-1:0] KEY_COLOR = DEF_KEY_COLOR
) (
    input logic          clk,
    input logic          reset,
    vga_frame_monitor_if.slave bus
);
    localparam logic [POS_W-1:0] H_DISP = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_DISP = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] H_FALL = POS_W'(sync_fall_pos(H_DISPLAY, H_FRONT));
    localparam logic [POS_W-1:0] H_RISE = POS_W'(sync_rise_pos(H_DISPLAY, H_FRONT, H_SYNC));
    localparam logic [POS_W-1:0] H_LAST = POS_W'(last_pos(H_DISPLAY, H_FRONT, H_SYNC, H_BACK));
    localparam logic [POS_W-1:0] V_FALL = POS_W'(sync_fall_pos(V_DISPLAY, V_FRONT));
    localparam logic [POS_W-1:0] V_RISE = POS_W'(sync_rise_pos(V_DISPLAY, V_FRONT, V_SYNC));
    localparam logic [POS_W-1:0] V_LAST = POS_W'(last_pos(V_DISPLAY, V_FRONT, V_SYNC, V_BACK));

    logic [POS_W-1:0] hcnt, vcnt, h_eff, v_eff, h_next, v_next;
    logic             h_fall, h_rise, v_fall, v_rise;
    logic             err_h_fall, err_h_rise, err_v_fall, err_v_rise, timing_err;
    logic             wrap, pix_active, key_hit;
    logic [SUM_W-1:0] sum_acc, sum_next, sum_q;
    logic [KEY_W-1:0] key_acc, key_next, key_q;
    logic [ERR_W-1:0] err_q;
    logic             active_q, locked_q, done_q, valid_q;
    mon_state_t       state;

    sync_edge_detect u_hsync (
        .clk     (clk),
        .reset   (reset),
        .p_tick  (bus.p_tick),
        .sync_in (bus.hsync),
        .fall    (h_fall),
        .rise    (h_rise)
    );

    sync_edge_detect u_vsync (
        .clk     (clk),
        .reset   (reset),
        .p_tick  (bus.p_tick),
        .sync_in (bus.vsync),
        .fall    (v_fall),
        .rise    (v_rise)
    );

    // check sync edges, realign the current sample and work out the next position
    always_comb begin
        err_h_fall = h_fall && (hcnt != H_FALL);
        err_h_rise = h_rise && (hcnt != H_RISE);
        err_v_fall = v_fall && !((hcnt == '0) && (vcnt == V_FALL));
        err_v_rise = v_rise && !((hcnt == '0) && (vcnt == V_RISE));
        timing_err = err_h_fall | err_h_rise | err_v_fall | err_v_rise;

        h_eff = hcnt;
        v_eff = vcnt;
        if (err_h_fall) begin
            h_eff = H_FALL;
        end
        if (err_v_fall) begin
            h_eff = '0;
            v_eff = V_FALL;
        end

        wrap   = (h_eff == H_LAST) && (v_eff == V_LAST);
        h_next = wrap_inc(h_eff, H_LAST);
        v_next = (h_eff == H_LAST) ? wrap_inc(v_eff, V_LAST) : v_eff;

        pix_active = (h_eff < H_DISP) && (v_eff < V_DISP);
        key_hit    = pix_active && (bus.rgb == KEY_COLOR);
        sum_next   = sum_acc + (pix_active ? {{(SUM_W-RGB_W){1'b0}}, bus.rgb} : '0);
        key_next   = key_acc + KEY_W'(key_hit);
    end

    // position, statistics and lock FSM; everything advances only on pixel ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt     <= '0;
            vcnt     <= '0;
            active_q <= 1'b1;
            state    <= SEARCH;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            sum_q    <= '0;
            key_q    <= '0;
            err_q    <= '0;
            sum_acc  <= '0;
            key_acc  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.p_tick) begin
                hcnt     <= h_next;
                vcnt     <= v_next;
                active_q <= (h_next < H_DISP) && (v_next < V_DISP);

                if (wrap) begin
                    sum_q   <= sum_next;
                    key_q   <= key_next;
                    sum_acc <= '0;
                    key_acc <= '0;
                    done_q  <= 1'b1;
                    // LOCKED is only entered at a wrap, so being LOCKED here
                    // means the whole frame was locked unless this tick errs
                    valid_q <= (state == LOCKED) && !timing_err;
                end else begin
                    sum_acc <= sum_next;
                    key_acc <= key_next;
                end

                case (state)
                    SEARCH: begin
                        if (v_fall) begin
                            state <= ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        if (timing_err) begin
                            state <= SEARCH;
                        end else if (wrap) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (timing_err) begin
                            state    <= SEARCH;
                            locked_q <= 1'b0;
                            if (err_q != '1) begin
                                err_q <= err_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.px_x        = hcnt;
    assign bus.px_y        = vcnt;
    assign bus.active      = active_q;
    assign bus.locked      = locked_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_sum   = sum_q;
    assign bus.key_count   = key_q;
    assign bus.err_count   = err_q;
endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor using a shrunken video mode (8x7 total,
// 4x3 active) so that many frames fit in a short run.
module tb_vga_frame_monitor;
    localparam int HD = 4, HFP = 1, HSW = 2, HBP = 1;
    localparam int VD = 3, VFP = 1, VSW = 1, VBP = 2;
    localparam int HT = HD + HFP + HSW + HBP;
    localparam int HF = HD + HFP;
    localparam int HR = HF + HSW;
    localparam int VT = VD + VFP + VSW + VBP;
    localparam int VF = VD + VFP;
    localparam int VR = VF + VSW;
    localparam int FT = HT * VT;
    localparam logic [11:0] KEY = 12'hf99;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_frame_monitor_if bus();

    vga_frame_monitor #(
        .H_DISPLAY (HD), .H_FRONT (HFP), .H_SYNC (HSW), .H_BACK (HBP),
        .V_DISPLAY (VD), .V_FRONT (VFP), .V_SYNC (VSW), .V_BACK (VBP),
        .KEY_COLOR (KEY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    // reference model: monitor's belief as one linear index into the frame
    int m_pos, m_state, m_err, m_acc, m_keys, m_sum_l, m_key_l;
    bit m_phs, m_pvs, m_valid_l, m_done;

    // stream generator
    int gen_idx = 0;
    int rgb_mode = 0;
    int gap_lo = 4;
    int gap_hi = 4;
    int tick_no = 0;
    int last_done = -1;
    bit spacing_on = 1'b0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_state = 0; m_err = 0; m_acc = 0; m_keys = 0;
        m_sum_l = 0; m_key_l = 0; m_phs = 1'b1; m_pvs = 1'b1;
        m_valid_l = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic hs, input logic vs, input logic [11:0] c);
        int p, h, v;
        bit fh, rh, fv, rv, err;
        p = m_pos; h = p % HT; v = p / HT;
        fh = m_phs && !hs; rh = !m_phs && hs;
        fv = m_pvs && !vs; rv = !m_pvs && vs;
        err = (fh && h != HF) || (rh && h != HR) || (fv && m_pos != VF * HT) ||
              (rv && m_pos != VR * HT);
        if (fh && h != HF) p = v * HT + HF;
        if (fv && m_pos != VF * HT) p = VF * HT;
        if ((p % HT) < HD && (p / HT) < VD) begin
            m_acc = (m_acc + int'(c)) % (1 << 24);
            if (c == KEY) m_keys++;
        end
        m_done = (p == FT - 1);
        if (m_done) begin
            m_sum_l = m_acc; m_key_l = m_keys; m_acc = 0; m_keys = 0;
            m_valid_l = (m_state == 2) && !err;
        end
        case (m_state)
            0: if (fv) m_state = 1;
            1: if (err) m_state = 0; else if (m_done) m_state = 2;
            default: if (err) begin
                m_state = 0;
                if (m_err < 255) m_err++;
            end
        endcase
        m_pos = (p + 1) % FT;
        m_phs = hs; m_pvs = vs;
    endtask

    task automatic send_tick(input logic hs, input logic vs, input logic [11:0] c);
        int gap;
        logic [30:0] e_pos;
        logic [43:0] e_stat;
        gap = (gap_hi > gap_lo) ? int'($urandom_range(gap_hi, gap_lo)) : gap_lo;
        for (int i = 1; i < gap; i++) begin
            @(negedge clk);
            check("done_width", {95'd0, bus.frame_done}, 96'd0);
        end
        bus.p_tick = 1'b1; bus.hsync = hs; bus.vsync = vs; bus.rgb = c;
        @(negedge clk);
        bus.p_tick = 1'b0;
        tick_no++;
        model_step(hs, vs, c);
        e_pos = {10'(m_pos % HT), 10'(m_pos / HT), ((m_pos % HT) < HD) && ((m_pos / HT) < VD),
                 m_state == 2, m_done, 8'(m_err)};
        e_stat = {24'(m_sum_l), 19'(m_key_l), m_valid_l};
        check("pos_state", 96'({bus.px_x, bus.px_y, bus.active, bus.locked, bus.frame_done,
                                bus.err_count}), 96'(e_pos));
        check("frame_stats", 96'({bus.frame_sum, bus.key_count, bus.frame_valid}), 96'(e_stat));
        if (bus.frame_done === 1'b1) begin
            if (spacing_on && last_done >= 0)
                check("done_spacing", 96'(tick_no - last_done), 96'(FT));
            last_done = tick_no;
        end
    endtask

    task automatic gen_tick(input bit inj, input bit shorten);
        int gh, gv;
        logic hs, vs;
        logic [11:0] c;
        gh = gen_idx % HT; gv = gen_idx / HT;
        hs = !(gh >= HF && gh < HR);
        vs = !(gv >= VF && gv < VR);
        if (shorten && gh == HR - 1) hs = 1'b1;
        if (inj) hs = 1'b0;
        case (rgb_mode)
            1: c = (gh < HD && gv < VD) ? KEY : 12'h000;
            2: c = 12'($urandom);
            default: c = 12'h000;
        endcase
        send_tick(hs, vs, c);
        gen_idx = (gen_idx + 1) % FT;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) gen_tick(1'b0, 1'b0);
    endtask

    task automatic advance_to(input int x, input int y);
        while (gen_idx != y * HT + x) gen_tick(1'b0, 1'b0);
    endtask

    task automatic inject_at(input int x, input int y);
        advance_to(x, y);
        gen_tick(1'b1, 1'b0);
    endtask

    task automatic wait_locked(input int max, input string tag);
        int n;
        n = 0;
        while (bus.locked !== 1'b1 && n < max) begin
            gen_tick(1'b0, 1'b0);
            n++;
        end
        check(tag, {95'd0, bus.locked}, 96'd1);
    endtask

    task automatic wait_done(input int max, input string tag);
        int n;
        n = 0;
        do begin
            gen_tick(1'b0, 1'b0);
            n++;
        end while (bus.frame_done !== 1'b1 && n < max);
        check(tag, {95'd0, bus.frame_done}, 96'd1);
    endtask

    task automatic do_reset();
        bus.p_tick = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("reset_pos", 96'({bus.px_x, bus.px_y, bus.active, bus.locked, bus.frame_done,
                                bus.err_count}), 96'({10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0}));
        check("reset_stats", 96'({bus.frame_sum, bus.key_count, bus.frame_valid}), 96'd0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_solid(input string tag);
        check({tag, "_keys"}, 96'(bus.key_count), 96'(HD * VD));
        check({tag, "_sum"}, 96'(bus.frame_sum), 96'((HD * VD * int'(KEY)) % (1 << 24)));
        check({tag, "_valid"}, {95'd0, bus.frame_valid}, 96'd1);
        check({tag, "_err"}, 96'(bus.err_count), 96'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.p_tick = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.rgb = 12'h000;
        gen_idx = 19;
        do_reset();

        // ideal stream, black pixels: lock lands on the first wrap after vsync fall
        rgb_mode = 0;
        wait_locked(3 * FT, "first_lock");
        check("lock_at_wrap", 96'(gen_idx), 96'd0);
        spacing_on = 1'b1;
        last_done = -1;
        run_ticks(3 * FT);
        check("ideal_err", 96'(bus.err_count), 96'd0);
        check("ideal_sum", 96'(bus.frame_sum), 96'd0);
        check("ideal_valid", {95'd0, bus.frame_valid}, 96'd1);

        // solid key colour inside the active area, black border
        rgb_mode = 1;
        run_ticks(2 * FT);
        check_solid("solid");

        // same stream with irregular pixel-tick gaps
        gap_lo = 4; gap_hi = 12;
        run_ticks(2 * FT);
        check_solid("gappy");
        check("gappy_locked", {95'd0, bus.locked}, 96'd1);
        spacing_on = 1'b0;

        // random colours everywhere, checked against the model
        rgb_mode = 2;
        run_ticks(3 * FT);

        // one hsync pulse cut short while locked
        rgb_mode = 0;
        advance_to(0, 1);
        repeat (HT) gen_tick(1'b0, 1'b1);
        check("short_err", 96'(bus.err_count), 96'd1);
        check("short_unlock", {95'd0, bus.locked}, 96'd0);
        wait_locked(3 * FT, "relock");
        check("relock_at_wrap", 96'(gen_idx), 96'd0);

        // reset in the middle of the active area while locked
        rgb_mode = 1;
        advance_to(HD / 2, VD / 2);
        do_reset();
        wait_done(2 * FT, "post_reset_done");
        check("post_reset_valid", {95'd0, bus.frame_valid}, 96'd0);

        // repeated misplaced hsync while locked, some also during acquisition
        rgb_mode = 0;
        gap_lo = 1; gap_hi = 1;
        for (int it = 0; it < 300; it++) begin
            wait_locked(3 * FT, "sat_lock");
            inject_at(1, 1);
            if (it % 10 == 0) inject_at(1, 5);
        end
        check("err_saturate", 96'(bus.err_count), 96'd255);
        check("sat_unlocked", {95'd0, bus.locked}, 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
